// File: rtl/alu_result_router_pkg.sv
// Shared definitions for the ALU writeback router and its decode/control peers.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
// Contents: wb_sel encodings, writeback FSM state encoding, flag bit indices,
// default datapath width, and a helper that classifies memory-port selects.
package alu_result_router_pkg;

  localparam int DW_DEFAULT = 16;

  // Destination select encodings, shared with the decode/control block.
  localparam logic [2:0] WB_SEL_NONE    = 3'b000;
  localparam logic [2:0] WB_SEL_REG     = 3'b001;
  localparam logic [2:0] WB_SEL_PC      = 3'b010;
  localparam logic [2:0] WB_SEL_STORE   = 3'b011;
  localparam logic [2:0] WB_SEL_LOAD    = 3'b100;
  localparam logic [2:0] WB_SEL_PUSH    = 3'b101;
  localparam logic [2:0] WB_SEL_POP     = 3'b110;
  localparam logic [2:0] WB_SEL_SP_LOAD = 3'b111;

  // Flag register bit positions, {N,Z,C,V}.
  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MEM  = 2'b01,
    ST_WB   = 2'b10
  } wb_state_t;

  // True for selects that produce a memory-port transaction.
  function automatic logic is_mem_op(input logic [2:0] sel);
    return (sel == WB_SEL_STORE) || (sel == WB_SEL_LOAD) ||
           (sel == WB_SEL_PUSH)  || (sel == WB_SEL_POP);
  endfunction

  // True for memory selects that write memory (STORE/PUSH).
  function automatic logic is_mem_write(input logic [2:0] sel);
    return (sel == WB_SEL_STORE) || (sel == WB_SEL_PUSH);
  endfunction

endpackage

// File: rtl/alu_result_router_wb_mem_fsm.sv
// Memory-port sequencer: IDLE/MEM/WB FSM with request, address and data latches.
// Latency: mem_req the cycle after start; done (WB) the cycle after a read ack.
// Backpressure: idle low from start until the transaction finishes; holds mem_req until mem_ack.
// Ports: clk/rst; start with sel/rd_idx/addr/wdata_in (request capture);
//   mem_req/mem_we/mem_addr/mem_wdata/mem_ack/mem_rdata (memory port);
//   idle, done (WB cycle), rd_idx_q/rdata (load writeback), push_done/pop_done (ack-edge pulses).
module alu_result_router_wb_mem_fsm
  import alu_result_router_pkg::*;
#(
  parameter int DW = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [2:0]    sel,
  input  logic [2:0]    rd_idx,
  input  logic [DW-1:0] addr,
  input  logic [DW-1:0] wdata_in,
  output logic          idle,
  output logic          mem_req,
  output logic          mem_we,
  output logic [DW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic          done,
  output logic [2:0]    rd_idx_q,
  output logic [DW-1:0] rdata,
  output logic          push_done,
  output logic          pop_done
);

  wb_state_t  state;
  logic [2:0] op_q;
  logic       ack_in_mem;

  // An ack only counts while a request is outstanding.
  assign ack_in_mem = (state == ST_MEM) && mem_ack;

  assign idle      = (state == ST_IDLE);
  assign done      = (state == ST_WB);
  assign push_done = ack_in_mem && (op_q == WB_SEL_PUSH);
  assign pop_done  = ack_in_mem && (op_q == WB_SEL_POP);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      op_q      <= WB_SEL_NONE;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rd_idx_q  <= '0;
      rdata     <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_MEM;
            op_q      <= sel;
            mem_req   <= 1'b1;
            mem_we    <= is_mem_write(sel);
            mem_addr  <= addr;
            mem_wdata <= is_mem_write(sel) ? wdata_in : '0;
            rd_idx_q  <= rd_idx;
          end
        end
        ST_MEM: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if ((op_q == WB_SEL_LOAD) || (op_q == WB_SEL_POP)) begin
              rdata <= mem_rdata;
              state <= ST_WB;
            end else begin
              state <= ST_IDLE;
            end
          end
        end
        ST_WB: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/alu_result_router.sv
// ALU writeback router: steers the ALU result to regfile, PC, SP or a memory transaction; owns SP and flags.
// Latency: REG/PC strobe 1 cycle after accept; memory ops complete 1 cycle (STORE/PUSH) or 2 cycles (LOAD/POP) after ack.
// Backpressure: wb_ready high only while idle; requests are ignored while a memory op is in flight.
// Ports: clk/rst; wb_valid/wb_ready/wb_sel/wb_reg/alu_result/store_data/alu_flags/flag_we (writeback request);
//   rf_we/rf_waddr/rf_wdata (register file); pc_load/pc_wdata (PC); sp, flags (architectural state);
//   mem_req/mem_we/mem_addr/mem_wdata/mem_ack/mem_rdata (memory port).
module alu_result_router
  import alu_result_router_pkg::*;
#(
  parameter int            DW      = DW_DEFAULT,
  parameter logic [DW-1:0] SP_INIT = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wb_valid,
  output logic          wb_ready,
  input  logic [2:0]    wb_sel,
  input  logic [2:0]    wb_reg,
  input  logic [DW-1:0] alu_result,
  input  logic [DW-1:0] store_data,
  input  logic [3:0]    alu_flags,
  input  logic          flag_we,
  output logic          rf_we,
  output logic [2:0]    rf_waddr,
  output logic [DW-1:0] rf_wdata,
  output logic          pc_load,
  output logic [DW-1:0] pc_wdata,
  output logic [DW-1:0] sp,
  output logic [3:0]    flags,
  output logic          mem_req,
  output logic          mem_we,
  output logic [DW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata
);

  logic          accept;
  logic          fsm_idle;
  logic          fsm_done;
  logic [2:0]    fsm_rd_idx;
  logic [DW-1:0] fsm_rdata;
  logic          push_done;
  logic          pop_done;

  logic          reg_we_q;
  logic [2:0]    reg_waddr_q;
  logic [DW-1:0] reg_wdata_q;

  assign wb_ready = fsm_idle;
  assign accept   = wb_valid && wb_ready;

  alu_result_router_wb_mem_fsm #(
    .DW (DW)
  ) u_mem_fsm (
    .clk       (clk),
    .rst       (rst),
    .start     (accept && is_mem_op(wb_sel)),
    .sel       (wb_sel),
    .rd_idx    (wb_reg),
    .addr      (alu_result),
    .wdata_in  (store_data),
    .idle      (fsm_idle),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .done      (fsm_done),
    .rd_idx_q  (fsm_rd_idx),
    .rdata     (fsm_rdata),
    .push_done (push_done),
    .pop_done  (pop_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      sp          <= SP_INIT;
      flags       <= '0;
      reg_we_q    <= 1'b0;
      reg_waddr_q <= '0;
      reg_wdata_q <= '0;
      pc_load     <= 1'b0;
      pc_wdata    <= '0;
    end else begin
      reg_we_q <= accept && (wb_sel == WB_SEL_REG);
      if (accept && (wb_sel == WB_SEL_REG)) begin
        reg_waddr_q <= wb_reg;
        reg_wdata_q <= alu_result;
      end

      pc_load <= accept && (wb_sel == WB_SEL_PC);
      if (accept && (wb_sel == WB_SEL_PC)) begin
        pc_wdata <= alu_result;
      end

      if (accept && flag_we) begin
        flags <= alu_flags;
      end

      // Accepts happen only in IDLE and acks only in MEM, so these never collide.
      // PUSH: the upstream mux already supplied sp-1 as the address, which is the new SP.
      if (accept && (wb_sel == WB_SEL_SP_LOAD)) begin
        sp <= alu_result;
      end else if (push_done) begin
        sp <= mem_addr;
      end else if (pop_done) begin
        sp <= sp + DW'(1);
      end
    end
  end

  // A REG pulse and a load writeback can never overlap: a REG accept needs IDLE
  // in the preceding cycle, while the WB cycle is always preceded by MEM.
  assign rf_we    = reg_we_q || fsm_done;
  assign rf_waddr = fsm_done ? fsm_rd_idx : reg_waddr_q;
  assign rf_wdata = fsm_done ? fsm_rdata  : reg_wdata_q;

endmodule

// File: tb/tb_alu_result_router.sv
module tb_alu_result_router;
  import alu_result_router_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid;
  logic        wb_ready;
  logic [2:0]  wb_sel;
  logic [2:0]  wb_reg;
  logic [15:0] alu_result;
  logic [15:0] store_data;
  logic [3:0]  alu_flags;
  logic        flag_we;
  logic        rf_we;
  logic [2:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic        pc_load;
  logic [15:0] pc_wdata;
  logic [15:0] sp;
  logic [3:0]  flags;
  logic        mem_req;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ack;
  logic [15:0] mem_rdata;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct packed {
    logic [2:0]  addr;
    logic [15:0] data;
  } rf_exp_t;

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
  } mem_exp_t;

  rf_exp_t     rf_q[$];
  logic [15:0] pc_q[$];
  mem_exp_t    mem_q[$];

  alu_result_router dut (
    .clk        (clk),
    .rst        (rst),
    .wb_valid   (wb_valid),
    .wb_ready   (wb_ready),
    .wb_sel     (wb_sel),
    .wb_reg     (wb_reg),
    .alu_result (alu_result),
    .store_data (store_data),
    .alu_flags  (alu_flags),
    .flag_we    (flag_we),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .pc_load    (pc_load),
    .pc_wdata   (pc_wdata),
    .sp         (sp),
    .flags      (flags),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h", tag, act, exp);
    end
  endtask

  // Drives one request and records what the DUT owes for it.
  task automatic drive(input logic [2:0] sel, input logic [2:0] r, input logic [15:0] res,
                       input logic [15:0] sd, input logic fwe, input logic [3:0] fl);
    mem_exp_t m;
    wb_valid   = 1'b1;
    wb_sel     = sel;
    wb_reg     = r;
    alu_result = res;
    store_data = sd;
    flag_we    = fwe;
    alu_flags  = fl;
    if (sel == WB_SEL_REG) rf_q.push_back('{addr: r, data: res});
    if (sel == WB_SEL_PC)  pc_q.push_back(res);
    if (is_mem_op(sel)) begin
      m.we    = is_mem_write(sel);
      m.addr  = res;
      m.wdata = sd;
      mem_q.push_back(m);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] sel, input logic [2:0] r, input logic [15:0] res,
                       input logic [15:0] sd, input logic fwe, input logic [3:0] fl);
    drive(sel, r, res, sd, fwe, fl);
    step();
    wb_valid = 1'b0;
    flag_we  = 1'b0;
  endtask

  // Scoreboard monitor: every strobe must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst) begin
      if (rf_we) begin
        if (rf_q.size() == 0) chk("rf_unexpected", 1, 0);
        else begin
          rf_exp_t e;
          e = rf_q.pop_front();
          chk("rf_waddr", 32'(rf_waddr), 32'(e.addr));
          chk("rf_wdata", 32'(rf_wdata), 32'(e.data));
        end
      end
      if (pc_load) begin
        if (pc_q.size() == 0) chk("pc_unexpected", 1, 0);
        else chk("pc_wdata", 32'(pc_wdata), 32'(pc_q.pop_front()));
      end
      if (mem_req) begin
        if (mem_q.size() == 0) chk("mem_unexpected", 1, 0);
        else begin
          chk("mem_we", 32'(mem_we), 32'(mem_q[0].we));
          chk("mem_addr", 32'(mem_addr), 32'(mem_q[0].addr));
          if (mem_q[0].we) chk("mem_wdata", 32'(mem_wdata), 32'(mem_q[0].wdata));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; wb_valid = 1'b0; wb_sel = WB_SEL_NONE; wb_reg = '0;
    alu_result = '0; store_data = '0; alu_flags = '0; flag_we = 1'b0;
    mem_ack = 1'b0; mem_rdata = '0;
    repeat (2) step();
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_ready", 32'(wb_ready), 1);
    chk("rst_sp", 32'(sp), 32'h0000);
    chk("rst_flags", 32'(flags), 0);
    chk("rst_rf_we", 32'(rf_we), 0);
    chk("rst_pc_load", 32'(pc_load), 0);
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_mem_we", 32'(mem_we), 0);
    step();

    // 1: REG with flag update
    issue(WB_SEL_REG, 3'd3, 16'h1234, 16'h0, 1'b1, 4'b0100);
    @(negedge clk);
    chk("t1_rf_we", 32'(rf_we), 1);
    chk("t1_flags", 32'(flags), 32'b0100);
    chk("t1_ready", 32'(wb_ready), 1);
    step();
    @(negedge clk);
    chk("t1_rf_we_pulse", 32'(rf_we), 0);
    step();

    // 2: PUSH from SP 0 to address FFFF, ack on third request cycle
    issue(WB_SEL_PUSH, 3'd0, 16'hFFFF, 16'hBEEF, 1'b0, 4'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t2_mem_req", 32'(mem_req), 1);
      chk("t2_ready", 32'(wb_ready), 0);
      chk("t2_sp_hold", 32'(sp), 32'h0000);
      if (i == 2) mem_ack = 1'b1;
      step();
    end
    mem_ack = 1'b0;
    void'(mem_q.pop_front());
    @(negedge clk);
    chk("t2_sp", 32'(sp), 32'hFFFF);
    chk("t2_mem_req_drop", 32'(mem_req), 0);
    chk("t2_ready", 32'(wb_ready), 1);
    step();

    // 3: POP at SP FFFF wraps to 0, ack on first request cycle
    issue(WB_SEL_POP, 3'd5, 16'hFFFF, 16'h0, 1'b0, 4'b0);
    @(negedge clk);
    chk("t3_mem_req", 32'(mem_req), 1);
    chk("t3_mem_we", 32'(mem_we), 0);
    mem_rdata = 16'hBEEF;
    mem_ack   = 1'b1;
    rf_q.push_back('{addr: 3'd5, data: 16'hBEEF});
    step();
    mem_ack = 1'b0;
    mem_rdata = 16'h0;
    void'(mem_q.pop_front());
    @(negedge clk);
    chk("t3_rf_we", 32'(rf_we), 1);
    chk("t3_sp_wrap", 32'(sp), 32'h0000);
    chk("t3_ready_wb", 32'(wb_ready), 0);
    step();
    @(negedge clk);
    chk("t3_rf_we_pulse", 32'(rf_we), 0);
    chk("t3_ready", 32'(wb_ready), 1);

    // 4: back-to-back REG, PC, SP_LOAD
    step();
    drive(WB_SEL_REG, 3'd1, 16'hAAAA, 16'h0, 1'b0, 4'b0);
    step();
    drive(WB_SEL_PC, 3'd0, 16'h0100, 16'h0, 1'b0, 4'b0);
    @(negedge clk);
    chk("t4_rf_we", 32'(rf_we), 1);
    chk("t4_pc_idle", 32'(pc_load), 0);
    step();
    drive(WB_SEL_SP_LOAD, 3'd0, 16'h8000, 16'h0, 1'b0, 4'b0);
    @(negedge clk);
    chk("t4_pc_load", 32'(pc_load), 1);
    chk("t4_rf_idle", 32'(rf_we), 0);
    step();
    wb_valid = 1'b0;
    @(negedge clk);
    chk("t4_sp", 32'(sp), 32'h8000);
    chk("t4_pc_pulse", 32'(pc_load), 0);
    chk("t4_flags", 32'(flags), 32'b0100);
    step();

    // 5: LOAD with wb_valid held (different request) while busy
    drive(WB_SEL_LOAD, 3'd2, 16'h1234, 16'h0, 1'b1, 4'b1010);
    step();
    wb_sel = WB_SEL_REG; alu_result = 16'h5555; alu_flags = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t5_ready", 32'(wb_ready), 0);
      chk("t5_flags", 32'(flags), 32'b1010);
      if (i == 2) begin
        mem_rdata = 16'hCAFE;
        mem_ack   = 1'b1;
        rf_q.push_back('{addr: 3'd2, data: 16'hCAFE});
      end
      step();
    end
    mem_ack = 1'b0;
    void'(mem_q.pop_front());
    @(negedge clk);
    chk("t5_rf_we", 32'(rf_we), 1);
    wb_valid = 1'b0;
    flag_we  = 1'b0;
    step();
    // spurious ack while idle
    mem_ack = 1'b1; mem_rdata = 16'hDEAD;
    step();
    mem_ack = 1'b0;
    @(negedge clk);
    chk("t5_spur_req", 32'(mem_req), 0);
    chk("t5_spur_ready", 32'(wb_ready), 1);
    chk("t5_spur_rf", 32'(rf_we), 0);
    chk("t5_spur_sp", 32'(sp), 32'h8000);
    step();

    // 6: reset during MEM of a STORE, then a late ack
    issue(WB_SEL_STORE, 3'd0, 16'h4000, 16'h7777, 1'b1, 4'b1111);
    @(negedge clk);
    chk("t6_mem_req", 32'(mem_req), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    mem_q.delete();
    @(negedge clk);
    chk("t6_req_drop", 32'(mem_req), 0);
    chk("t6_ready", 32'(wb_ready), 1);
    chk("t6_sp", 32'(sp), 32'h0000);
    chk("t6_flags", 32'(flags), 0);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    @(negedge clk);
    chk("t6_late_ack_req", 32'(mem_req), 0);
    chk("t6_late_ack_ready", 32'(wb_ready), 1);
    step();

    // 2-cycle STORE: ack in the first request cycle
    issue(WB_SEL_STORE, 3'd0, 16'h0010, 16'h1111, 1'b0, 4'b0);
    @(negedge clk);
    chk("t7_mem_req", 32'(mem_req), 1);
    mem_ack = 1'b1;
    step();
    mem_ack = 1'b0;
    void'(mem_q.pop_front());
    @(negedge clk);
    chk("t7_ready", 32'(wb_ready), 1);
    chk("t7_req_drop", 32'(mem_req), 0);
    chk("t7_sp", 32'(sp), 32'h0000);
    step();

    chk("rf_q_empty", 32'(rf_q.size()), 0);
    chk("pc_q_empty", 32'(pc_q.size()), 0);
    chk("mem_q_empty", 32'(mem_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_result_router.md
Name: alu_result_router

Overview:
- Writeback end of the ALU datapath; the counterpart of the operand-select mux that feeds the ALU.
- Takes the ALU result plus a destination select and routes it to the register file, PC, stack pointer, or a memory-port transaction (store/load/push/pop).
- Owns the architectural SP (full-descending stack) and the flag register.
- Sits between the ALU output and the register file / memory interface.

Parameters:
DW, 16, datapath width
SP_INIT, 16'h0000, SP value after reset; the first push writes address 16'hFFFF

Ports:
clk  in  1  clock, all state updates on rising edge
rst  in  1  reset; synchronous, active-high
wb_valid  in  1  writeback request valid
wb_ready  out  1  router can accept; high only in IDLE
wb_sel  in  3  destination select (encodings below)
wb_reg  in  3  destination register index for REG/LOAD/POP
alu_result  in  DW  ALU output; the value, or the memory address for memory ops
store_data  in  DW  data for STORE/PUSH
alu_flags  in  4  {N,Z,C,V} from ALU
flag_we  in  1  update flags on accept
rf_we  out  1  register-file write strobe, 1-cycle pulse
rf_waddr  out  3  register index
rf_wdata  out  DW  register write data
pc_load  out  1  PC load strobe, 1-cycle pulse
pc_wdata  out  DW  new PC
sp  out  DW  current stack pointer
flags  out  4  {N,Z,C,V} register
mem_req  out  1  memory request, held until ack
mem_we  out  1  1=write, 0=read, valid with mem_req
mem_addr  out  DW  memory address
mem_wdata  out  DW  write data
mem_ack  in  1  memory completion
mem_rdata  in  DW  read data, valid with mem_ack on reads

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state IDLE, sp=SP_INIT, flags=0, and all strobes 0 (rf_we, pc_load, mem_req, mem_we). Data outputs reset to 0.
- wb_sel encodings:
  - 000 NONE
  - 001 REG
  - 010 PC
  - 011 STORE
  - 100 LOAD
  - 101 PUSH
  - 110 POP
  - 111 SP_LOAD
- Accept condition: wb_valid && wb_ready. wb_ready = (state==IDLE). Nothing is accepted while busy, and inputs are ignored then.
- flag_we at accept: flags<=alu_flags on that same edge, for any wb_sel.
- Single-cycle ops; state stays IDLE, so back-to-back accepts every cycle are allowed:
  - REG: rf_we=1, rf_waddr=wb_reg, rf_wdata=alu_result, in the cycle after accept.
  - PC: pc_load=1, pc_wdata=alu_result, in the cycle after accept.
  - SP_LOAD: sp<=alu_result on the accept edge.
  - NONE: only the flag update (if flag_we).
- Memory ops: IDLE->MEM on accept.
  - mem_req=1 from the next cycle, with mem_addr=alu_result and mem_we=1 for STORE/PUSH, 0 for LOAD/POP.
  - mem_wdata=store_data for STORE/PUSH.
  - Address and data are latched at accept and held stable while mem_req=1.
- In MEM, on mem_ack:
  - mem_req<=0 on the same edge.
  - STORE -> IDLE.
  - PUSH -> IDLE, with sp<=latched address. The mux already presents sp-1, so the address is the new SP.
  - LOAD/POP -> WB, with mem_rdata captured. POP also sets sp<=sp+1 on this edge.
- WB state: rf_we=1, rf_waddr=latched wb_reg, rf_wdata=captured rdata, for exactly one cycle, then -> IDLE.
- Latency:
  - REG/PC: strobe 1 cycle after accept.
  - STORE/PUSH: ready again 1 cycle after ack.
  - LOAD/POP: rf_we 1 cycle after ack, ready the cycle after that.
- The earliest ack is in the first mem_req cycle, giving a 2-cycle STORE (accept, req+ack).
- SP arithmetic is modulo 2^DW: POP at 16'hFFFF gives 16'h0000. PUSH address 16'hFFFF from SP 0 is legal.
- mem_ack while mem_req=0 is ignored.
- Reset mid-transaction: abort to IDLE, drop mem_req immediately, and leave sp/flags unchanged by the aborted op (both take reset values).
- sp output is registered. An SP change becomes visible the cycle after the updating edge, and the upstream mux compensates for this.

Decomposition:
- Shared package:
  - WB_SEL_* encodings (shared with the decode/control block)
  - state encoding IDLE/MEM/WB
  - flag bit indices FLAG_N/Z/C/V
  - DW default
- One natural sub-module: wb_mem_fsm. It holds the IDLE/MEM/WB FSM, the request/address/data latches and the ack handling, and exports done/rdata.
- The top level keeps the SP, flags and single-cycle strobes.

Test Plan:
1. Reset, then REG: wb_sel=001, wb_reg=3, alu_result=16'h1234, flag_we=1, alu_flags=4'b0100 -> next cycle rf_we=1, rf_waddr=3, rf_wdata=16'h1234, flags=4'b0100; wb_ready stays 1.
2. PUSH after reset (sp=0): alu_result=16'hFFFF, store_data=16'hBEEF, mem_ack after 3 req cycles -> mem_req/mem_we=1, addr 16'hFFFF, wdata 16'hBEEF held 3 cycles; sp=16'hFFFF after ack; wb_ready 0 until the cycle after ack.
3. POP at sp=16'hFFFF: alu_result=16'hFFFF, wb_reg=5, ack with mem_rdata=16'hBEEF -> mem_we=0; sp becomes 16'h0000 (wrap); rf_we pulse the cycle after ack with rf_waddr=5, rf_wdata=16'hBEEF.
4. Back-to-back REG, PC, SP_LOAD(16'h8000) on consecutive cycles -> rf_we, then pc_load (pc_wdata correct), then sp=16'h8000; no lost request.
5. wb_valid held during LOAD wait, plus a spurious mem_ack in IDLE -> no accept while busy, no state change from the spurious ack.
6. rst asserted during MEM of a STORE -> next cycle mem_req=0, state IDLE, sp=SP_INIT, wb_ready=1; a later ack is ignored.
